// File: rtl/fwd_bypass_unit.sv
// fwd_bypass_unit -- operand forwarding for the 16-bit pipelined core.
// Keeps the last DEPTH register writebacks in a shift-register history.
// Each source operand takes the youngest matching in-flight value, or the
// register-file value when nothing matches. A matching load that has not
// returned yet raises a combinational load-use stall.
// Optional build macro FWD_PERF_CNT_EN adds the o_fwd_cnt / o_stall_cnt
// performance counters.
module fwd_bypass_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int DEPTH   = 2,
    parameter int NUM_SRC = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_advance,
    input  logic                        i_flush,
    input  logic                        i_wr_en,
    input  logic [ADDR_W-1:0]           i_wr_addr,
    input  logic [DATA_W-1:0]           i_wr_data,
    input  logic                        i_wr_pending,
    input  logic [DATA_W-1:0]           i_ld_data,
    input  logic [NUM_SRC*ADDR_W-1:0]   i_src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]   i_rf_data,
    output logic [NUM_SRC*DATA_W-1:0]   o_src_data,
    output logic [NUM_SRC-1:0]          o_fwd_hit,
`ifdef FWD_PERF_CNT_EN
    output logic [31:0]                 o_fwd_cnt,
    output logic [31:0]                 o_stall_cnt,
`endif
    output logic                        o_stall
);

    // History storage; entry 0 is the youngest producer.
    logic [DEPTH-1:0]             r_vld;
    logic [DEPTH-1:0]             r_pend;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;

    // Per-operand stall requests, OR-reduced into o_stall.
    logic [NUM_SRC-1:0]           w_stall_src;

    // History update: reset, then flush (no shift, write dropped), then shift.
    // A pending load in entry 0 picks up i_ld_data as it moves into entry 1,
    // so only entry 0 can ever be pending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld  <= '0;
            r_pend <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else if (i_flush) begin
            r_vld  <= '0;
            r_pend <= '0;
        end else if (i_advance) begin
            r_vld[0]  <= i_wr_en;
            r_pend[0] <= i_wr_en & i_wr_pending;
            r_addr[0] <= i_wr_addr;
            r_data[0] <= i_wr_data;

            r_vld[1]  <= r_vld[0];
            r_pend[1] <= 1'b0;
            r_addr[1] <= r_addr[0];
            r_data[1] <= r_pend[0] ? i_ld_data : r_data[0];

            for (int i = 2; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_pend[i] <= r_pend[i-1];
                r_addr[i] <= r_addr[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    // Per-operand match and select; no register is special, address 0 included.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_rf;
        logic              w_hit;
        logic              w_pend;
        logic [DATA_W-1:0] w_data;

        assign w_addr = i_src_addr[k*ADDR_W +: ADDR_W];
        assign w_rf   = i_rf_data[k*DATA_W +: DATA_W];

        // Scan oldest to youngest so the lowest matching index wins;
        // older duplicates of the same register are shadowed.
        always_comb begin
            w_hit  = 1'b0;
            w_pend = 1'b0;
            w_data = '0;
            for (int i = DEPTH-1; i >= 0; i--) begin
                if (r_vld[i] && (r_addr[i] == w_addr)) begin
                    w_hit  = 1'b1;
                    w_pend = r_pend[i];
                    w_data = r_data[i];
                end
            end
        end

        // A pending winner stalls and falls back to the register file.
        assign o_fwd_hit[k]                 = w_hit & ~w_pend;
        assign w_stall_src[k]               = w_hit & w_pend;
        assign o_src_data[k*DATA_W +: DATA_W] = (w_hit && !w_pend) ? w_data : w_rf;
    end

    assign o_stall = |w_stall_src;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] r_fwd_cnt;
    logic [31:0] r_stall_cnt;

    // Free-running wrap-around counters; flush leaves them alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fwd_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if ((|o_fwd_hit) && i_advance) r_fwd_cnt <= r_fwd_cnt + 32'd1;
            if (o_stall)                   r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_fwd_cnt   = r_fwd_cnt;
    assign o_stall_cnt = r_stall_cnt;
`else
    // Counters not built.
`endif

endmodule
